// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: fills the FIFO pair with a seeded ramp, drains it into the MAC, captures the sum and reports IDLE/FILL/EXEC/DONE on state; define MAC_SEQ_TIMEOUT_EN for a stall watchdog driving error
module mac_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int MAC_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_rd,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic [1:0]        state,
  output logic              error
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, EXEC = 2'd2, DONE = 2'd3;
  logic [1:0] next_state;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [DATA_W-1:0] seed_q;
  logic [7:0] lat_cnt;
  logic go, fill_done, drained, capture, timeout;
  always_ff @(posedge clk) state <= rst ? IDLE : next_state;
  always_comb next_state = go ? FILL : timeout ? DONE : fill_done ? EXEC : capture ? DONE : state;
  always_comb begin
    go = (state == IDLE || state == DONE) && start;
    fifo_wr = state == FILL && !fifo_full && wr_cnt < CW'(DEPTH);
    fifo_rd = state == EXEC && !fifo_empty && rd_cnt < CW'(DEPTH);
    fifo_wdata = seed_q + DATA_W'(wr_cnt);
    fill_done = state == FILL && (wr_cnt == CW'(DEPTH) || (fifo_wr && wr_cnt == CW'(DEPTH - 1)));
    drained = state == EXEC && rd_cnt == CW'(DEPTH) && !mac_en;
    capture = drained && lat_cnt == 8'(MAC_LAT - 1);
    result_valid = state == DONE && !error;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {wr_cnt, rd_cnt, seed_q, lat_cnt, result} <= '0;
      mac_en <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      mac_clr <= go;
      mac_en <= fifo_rd;
      seed_q <= go ? seed : seed_q;
      wr_cnt <= go ? '0 : wr_cnt + CW'(fifo_wr);
      rd_cnt <= go ? '0 : rd_cnt + CW'(fifo_rd);
      lat_cnt <= go ? '0 : lat_cnt + 8'(drained);
      result <= capture ? mac_acc : result;
    end
  end
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic stall;
  always_comb begin
    stall = (state == FILL && !fifo_wr) || (state == EXEC && !fifo_rd && rd_cnt < CW'(DEPTH));
    timeout = stall && wd_cnt == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      error <= 1'b0;
    end else begin
      wd_cnt <= (stall && !timeout) ? wd_cnt + TW'(1) : '0;
      error <= go ? 1'b0 : timeout ? 1'b1 : error;
    end
  end
`else
  always_comb timeout = 1'b0;
  assign error = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl with a queue FIFO and sum-of-products MAC model (operand B fixed at 2)
module tb_mac_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, force_full = 0, force_empty = 0;
  logic [7:0] seed = 0;
  logic fifo_full, fifo_empty, fifo_wr, fifo_rd, mac_en, mac_clr, result_valid, error;
  logic [7:0] fifo_wdata, rdata;
  logic [23:0] mac_acc, result;
  logic [1:0] state;
  logic [7:0] q[$];
  int qn = 0, tests = 0, fails = 0;
  mac_seq_ctrl #(.DEPTH(8), .DATA_W(8), .ACC_W(24), .MAC_LAT(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_rd(fifo_rd),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_acc(mac_acc),
    .result(result), .result_valid(result_valid), .state(state), .error(error)
  );
  always #5 clk = ~clk;
  assign fifo_full = force_full;
  assign fifo_empty = force_empty || qn == 0;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      qn <= 0;
      mac_acc <= '0;
      rdata <= '0;
    end else begin
      if (mac_clr) mac_acc <= '0;
      else if (mac_en) mac_acc <= mac_acc + 24'(rdata) * 24'd2;
      if (fifo_wr) q.push_back(fifo_wdata);
      if (fifo_rd && q.size() > 0) rdata <= q.pop_front();
      qn <= q.size();
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input logic [7:0] s);
    seed = s;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (fifo_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
    tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
    tests++; if (mac_en !== 1'b0) begin fails++; $display("FAIL reset_mac_en: got %b want 0", mac_en); end
    tests++; if (mac_clr !== 1'b0) begin fails++; $display("FAIL reset_mac_clr: got %b want 0", mac_clr); end
    tests++; if (result !== 24'd0) begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    rst = 0;
    tick();
  endtask
  task automatic test_fill_ramp();
    kick(8'h05);
    for (int i = 0; i < 8; i++) begin
      tests++; if (fifo_wr !== 1'b1) begin fails++; $display("FAIL ramp_wr[%0d]: got %b want 1", i, fifo_wr); end
      tests++; if (fifo_wdata !== 8'(5 + i)) begin fails++; $display("FAIL ramp_data[%0d]: got %h want %h", i, fifo_wdata, 8'(5 + i)); end
      if (i == 0) begin
        tests++; if (mac_clr !== 1'b1) begin fails++; $display("FAIL ramp_mac_clr: got %b want 1", mac_clr); end
      end
      tick();
    end
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL ramp_exec: got %0d want 2", state); end
    tests++; if (fifo_wr !== 1'b0) begin fails++; $display("FAIL ramp_no_wr: got %b want 0", fifo_wr); end
    for (int i = 0; i < 40 && state !== 2'd3; i++) tick();
    tests++; if (result !== 24'd136) begin fails++; $display("FAIL ramp_result: got %0d want 136", result); end
  endtask
  task automatic test_wrap_backpressure();
    logic [7:0] e;
    int k = 0;
    kick(8'hFC);
    for (int c = 0; c < 12; c++) begin
      force_full = c >= 2 && c < 6;
      #1;
      if (force_full) begin
        tests++; if (fifo_wr !== 1'b0) begin fails++; $display("FAIL wrap_stall_wr[%0d]: got %b want 0", c, fifo_wr); end
      end else begin
        e = 8'hFC + 8'(k);
        k++;
        tests++; if (fifo_wr !== 1'b1 || fifo_wdata !== e) begin fails++; $display("FAIL wrap_data[%0d]: got wr=%b %h want wr=1 %h", c, fifo_wr, fifo_wdata, e); end
      end
      tick();
    end
    force_full = 0;
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL wrap_exec: got %0d want 2", state); end
    for (int i = 0; i < 40 && state !== 2'd3; i++) tick();
    tests++; if (result !== 24'd2040) begin fails++; $display("FAIL wrap_result: got %0d want 2040", result); end
  endtask
  task automatic test_exec_capture();
    int n_en = 0;
    bit both = 0;
    kick(8'h01);
    for (int t = 1; t <= 19; t++) begin
      if (t > 1) tick();
      n_en += int'(mac_en);
      both |= fifo_wr && fifo_rd;
      if (t == 18) begin
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL exec_early_valid: got %b want 0", result_valid); end
      end
    end
    tests++; if (both) begin fails++; $display("FAIL exec_wr_rd_overlap: got 1 want 0"); end
    tests++; if (n_en != 8) begin fails++; $display("FAIL exec_mac_en_count: got %0d want 8", n_en); end
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL exec_valid_19: got %b want 1", result_valid); end
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL exec_state: got %0d want 3", state); end
    tests++; if (result !== 24'd72) begin fails++; $display("FAIL exec_result: got %0d want 72", result); end
  endtask
  task automatic test_reset_mid_exec();
    int n_rd = 0;
    kick(8'h01);
    for (int i = 0; i < 40 && n_rd < 3; i++) begin
      n_rd += int'(fifo_rd);
      tick();
    end
    rst = 1;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL midrst_state: got %0d want 0", state); end
    tests++; if ({fifo_wr, fifo_rd, mac_en, mac_clr} !== 4'b0) begin fails++; $display("FAIL midrst_strobes: got %b want 0000", {fifo_wr, fifo_rd, mac_en, mac_clr}); end
    tests++; if (result !== 24'd0 || result_valid !== 1'b0) begin fails++; $display("FAIL midrst_result: got %0d/%b want 0/0", result, result_valid); end
    rst = 0;
    tick();
    kick(8'h01);
    for (int i = 0; i < 40 && state !== 2'd3; i++) tick();
    tests++; if (result !== 24'd72 || result_valid !== 1'b1) begin fails++; $display("FAIL midrst_rerun: got %0d/%b want 72/1", result, result_valid); end
  endtask
  task automatic test_timeout();
    kick(8'h01);
    for (int i = 0; i < 40 && state !== 2'd2; i++) tick();
    force_empty = 1;
`ifdef MAC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    tests++; if (state !== 2'd2 || error !== 1'b0) begin fails++; $display("FAIL to_early: got state=%0d err=%b want 2/0", state, error); end
    tick();
    tests++; if (state !== 2'd3 || error !== 1'b1) begin fails++; $display("FAIL to_fire: got state=%0d err=%b want 3/1", state, error); end
    tests++; if (result_valid !== 1'b0 || result !== 24'd72) begin fails++; $display("FAIL to_result: got %0d/%b want 72/0", result, result_valid); end
    force_empty = 0;
    kick(8'h01);
    tests++; if (error !== 1'b0 || state !== 2'd1) begin fails++; $display("FAIL to_clear: got err=%b state=%0d want 0/1", error, state); end
`else
    for (int i = 0; i < 20; i++) tick();
    tests++; if (state !== 2'd2 || error !== 1'b0) begin fails++; $display("FAIL stall_wait: got state=%0d err=%b want 2/0", state, error); end
    force_empty = 0;
`endif
    for (int i = 0; i < 40 && state !== 2'd3; i++) tick();
    tests++; if (result !== 24'd72 || result_valid !== 1'b1) begin fails++; $display("FAIL stall_finish: got %0d/%b want 72/1", result, result_valid); end
  endtask
  initial begin
    test_reset();
    test_fill_ramp();
    test_wrap_backpressure();
    test_exec_capture();
    test_reset_mid_exec();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
